// File: rtl/rv32im_decode_exec.sv
// rv32im_decode_exec: decodes one RV32IM instruction into a single ID/EX
// register, then computes the ALU result and branch decision from it.
// Ports: CLK, RESET (sync, active-low), STALL, FLUSH, INSTRUCTION, PC_IN,
//   DATA1/DATA2 (forwarded rs1/rs2) in; ALU_OUT, BRANCH_TAKEN,
//   REG_WRITE_EN/SEL, MEM_READ, MEM_WRITE, RD_ADDR, STORE_DATA, PC_OUT out.
// Macro M_EXT_EN: when defined, enables MUL/DIV decode and datapath.
module rv32im_decode_exec (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [31:0] INSTRUCTION,
  input  logic [31:0] PC_IN,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  output logic [31:0] ALU_OUT,
  output logic        BRANCH_TAKEN,
  output logic        REG_WRITE_EN,
  output logic [1:0]  REG_WRITE_SEL,
  output logic [3:0]  MEM_READ,
  output logic [2:0]  MEM_WRITE,
  output logic [4:0]  RD_ADDR,
  output logic [31:0] STORE_DATA,
  output logic [31:0] PC_OUT
);

  typedef struct packed {
    logic [4:0]  alu;
    logic [3:0]  br;
    logic        op1_pc;
    logic        op2_imm;
    logic        jalr;
    logic        we;
    logic [1:0]  wsel;
    logic [3:0]  mrd;
    logic [2:0]  mwr;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
  } id_ex_t;

  localparam logic [4:0] A_ADD  = 5'b00000;
  localparam logic [4:0] A_SLL  = 5'b00001;
  localparam logic [4:0] A_SLT  = 5'b00010;
  localparam logic [4:0] A_SLTU = 5'b00011;
  localparam logic [4:0] A_XOR  = 5'b00100;
  localparam logic [4:0] A_SRL  = 5'b00101;
  localparam logic [4:0] A_OR   = 5'b00110;
  localparam logic [4:0] A_AND  = 5'b00111;
  localparam logic [4:0] A_SUB  = 5'b10000;
  localparam logic [4:0] A_SRA  = 5'b10101;
  localparam logic [4:0] A_FWD  = 5'b10001;

  id_ex_t ex, nx;

  logic [31:0] ins;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        op_alt, op_m, op_ok;

  assign ins = INSTRUCTION;
  assign opc = ins[6:0];
  assign f3  = ins[14:12];
  assign f7  = ins[31:25];

  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};

  // funct7 0100000 is only legal for SUB and SRA
  assign op_alt = (f7 == 7'b0100000) && (f3 == 3'b000 || f3 == 3'b101);
`ifdef M_EXT_EN
  assign op_m = (f7 == 7'b0000001);
`else
  assign op_m = 1'b0;
`endif
  assign op_ok = (f7 == 7'b0) || op_alt || op_m;

  always_comb begin
    nx = '0;
    nx.rd = ins[11:7];
    nx.pc = PC_IN;
    nx.d1 = DATA1;
    nx.d2 = DATA2;
    unique case (1'b1)
      (opc == 7'b0110111): begin
        nx.alu = A_FWD; nx.op2_imm = 1'b1; nx.imm = imm_u;
        nx.we = 1'b1; nx.wsel = 2'd1;
      end
      (opc == 7'b0010111): begin
        nx.op1_pc = 1'b1; nx.op2_imm = 1'b1; nx.imm = imm_u;
        nx.we = 1'b1; nx.wsel = 2'd1;
      end
      (opc == 7'b1101111): begin
        nx.op1_pc = 1'b1; nx.op2_imm = 1'b1; nx.imm = imm_j;
        nx.we = 1'b1; nx.wsel = 2'd3; nx.br = 4'b1010;
      end
      (opc == 7'b1100111): begin
        nx.op2_imm = 1'b1; nx.imm = imm_i; nx.jalr = 1'b1;
        nx.we = 1'b1; nx.wsel = 2'd3; nx.br = 4'b1010;
      end
      (opc == 7'b1100011): begin
        nx.op1_pc = 1'b1; nx.op2_imm = 1'b1; nx.imm = imm_b;
        // funct3 010/011 are not branches; keep them from aliasing 1010
        nx.br = (f3[2:1] == 2'b01) ? 4'b0000 : {1'b1, f3};
      end
      (opc == 7'b0000011): begin
        nx.op2_imm = 1'b1; nx.imm = imm_i;
        nx.we = 1'b1; nx.wsel = 2'd0; nx.mrd = {1'b1, f3};
      end
      (opc == 7'b0100011): begin
        nx.op2_imm = 1'b1; nx.imm = imm_s;
        nx.mwr = {1'b1, f3[1:0]};
      end
      (opc == 7'b0010011): begin
        nx.op2_imm = 1'b1; nx.imm = imm_i;
        nx.alu = {(f3 == 3'b101) && ins[30], 1'b0, f3};
        nx.we = 1'b1; nx.wsel = 2'd1;
      end
      (opc == 7'b0110011): begin
        if (op_ok) begin
          nx.alu = {op_alt, op_m, f3};
          nx.we = 1'b1; nx.wsel = 2'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET)      ex <= '0;
    else if (FLUSH)  ex <= '0;
    else if (!STALL) ex <= nx;
  end

  logic [31:0] op1, op2, res;
  logic [4:0]  sh;

  assign op1 = ex.op1_pc  ? ex.pc  : ex.d1;
  assign op2 = ex.op2_imm ? ex.imm : ex.d2;
  assign sh  = op2[4:0];

`ifdef M_EXT_EN
  logic signed [63:0] ma, mb, prod;
  logic               ovf, dz;

  // one 64-bit multiplier serves all four MUL variants via operand extension
  assign ma   = (ex.alu == 5'b01001 || ex.alu == 5'b01010) ?
                {{32{op1[31]}}, op1} : {32'b0, op1};
  assign mb   = (ex.alu == 5'b01001) ? {{32{op2[31]}}, op2} : {32'b0, op2};
  assign prod = ma * mb;
  assign dz   = (op2 == 32'b0);
  assign ovf  = (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);
`endif

  always_comb begin
    res = 32'b0;
    case (ex.alu)
      A_ADD:  res = op1 + op2;
      A_SUB:  res = op1 - op2;
      A_SLL:  res = op1 << sh;
      A_SLT:  res = {31'b0, $signed(op1) < $signed(op2)};
      A_SLTU: res = {31'b0, op1 < op2};
      A_XOR:  res = op1 ^ op2;
      A_SRL:  res = op1 >> sh;
      A_SRA:  res = $signed(op1) >>> sh;
      A_OR:   res = op1 | op2;
      A_AND:  res = op1 & op2;
      A_FWD:  res = op2;
`ifdef M_EXT_EN
      5'b01000: res = prod[31:0];
      5'b01001,
      5'b01010,
      5'b01011: res = prod[63:32];
      5'b01100: res = dz ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 :
                      $signed(op1) / $signed(op2);
      5'b01101: res = dz ? 32'hFFFF_FFFF : op1 / op2;
      5'b01110: res = dz ? op1 : ovf ? 32'b0 :
                      $signed(op1) % $signed(op2);
      5'b01111: res = dz ? op1 : op1 % op2;
`endif
      default: res = 32'b0;
    endcase
  end

  assign ALU_OUT = ex.jalr ? {res[31:1], 1'b0} : res;

  always_comb begin
    BRANCH_TAKEN = 1'b0;
    case (ex.br)
      4'b1000: BRANCH_TAKEN = (ex.d1 == ex.d2);
      4'b1001: BRANCH_TAKEN = (ex.d1 != ex.d2);
      4'b1100: BRANCH_TAKEN = ($signed(ex.d1) < $signed(ex.d2));
      4'b1101: BRANCH_TAKEN = ($signed(ex.d1) >= $signed(ex.d2));
      4'b1110: BRANCH_TAKEN = (ex.d1 < ex.d2);
      4'b1111: BRANCH_TAKEN = (ex.d1 >= ex.d2);
      4'b1010: BRANCH_TAKEN = 1'b1;
      default: BRANCH_TAKEN = 1'b0;
    endcase
  end

  assign REG_WRITE_EN  = ex.we;
  assign REG_WRITE_SEL = ex.wsel;
  assign MEM_READ      = ex.mrd;
  assign MEM_WRITE     = ex.mwr;
  assign RD_ADDR       = ex.rd;
  assign STORE_DATA    = ex.d2;
  assign PC_OUT        = ex.pc;

endmodule

// File: tb/tb_rv32im_decode_exec.sv
// tb_rv32im_decode_exec: directed vectors with hand-computed results
// for the rv32im_decode_exec ID/EX slice.
module tb_rv32im_decode_exec;

  logic        CLK = 1'b0;
  logic        RESET, STALL, FLUSH;
  logic [31:0] INSTRUCTION, PC_IN, DATA1, DATA2;
  logic [31:0] ALU_OUT;
  logic        BRANCH_TAKEN;
  logic        REG_WRITE_EN;
  logic [1:0]  REG_WRITE_SEL;
  logic [3:0]  MEM_READ;
  logic [2:0]  MEM_WRITE;
  logic [4:0]  RD_ADDR;
  logic [31:0] STORE_DATA, PC_OUT;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  rv32im_decode_exec dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
    .INSTRUCTION(INSTRUCTION), .PC_IN(PC_IN),
    .DATA1(DATA1), .DATA2(DATA2),
    .ALU_OUT(ALU_OUT), .BRANCH_TAKEN(BRANCH_TAKEN),
    .REG_WRITE_EN(REG_WRITE_EN), .REG_WRITE_SEL(REG_WRITE_SEL),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .RD_ADDR(RD_ADDR),
    .STORE_DATA(STORE_DATA), .PC_OUT(PC_OUT)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [31:0] i, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] b);
    INSTRUCTION = i; PC_IN = pc; DATA1 = a; DATA2 = b;
    @(posedge CLK);
    #1;
  endtask

  logic [31:0] jal_alu, jal_pc;

  initial begin
    RESET = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
    step(32'h0010_00EF, 32'h0000_0400, 32'h1234_5678, 32'h9ABC_DEF0);
    chk("rst_alu", ALU_OUT, 32'h0);
    chk("rst_br", {31'b0, BRANCH_TAKEN}, 32'h0);
    chk("rst_ctl", {REG_WRITE_EN, REG_WRITE_SEL, MEM_READ, MEM_WRITE,
                    RD_ADDR}, 32'h0);
    chk("rst_pc", PC_OUT, 32'h0);
    RESET = 1'b1;

    step(32'hFFF0_0293, 32'h0, 32'h0, 32'h0);
    chk("addi_alu", ALU_OUT, 32'hFFFF_FFFF);
    chk("addi_we", {31'b0, REG_WRITE_EN}, 32'h1);
    chk("addi_sel", {30'b0, REG_WRITE_SEL}, 32'h1);
    chk("addi_rd", {27'b0, RD_ADDR}, 32'h5);

    step(32'h0020_C463, 32'h100, 32'hFFFF_FFFF, 32'h1);
    chk("blt_tk", {31'b0, BRANCH_TAKEN}, 32'h1);
    chk("blt_tgt", ALU_OUT, 32'h108);
    chk("blt_we", {31'b0, REG_WRITE_EN}, 32'h0);

    step(32'h0020_E463, 32'h100, 32'hFFFF_FFFF, 32'h1);
    chk("bltu_tk", {31'b0, BRANCH_TAKEN}, 32'h0);
    chk("bltu_tgt", ALU_OUT, 32'h108);

    step(32'h0020_A223, 32'h0, 32'h1000, 32'hAB);
    chk("sw_alu", ALU_OUT, 32'h1004);
    chk("sw_mw", {29'b0, MEM_WRITE}, 32'h6);
    chk("sw_sd", STORE_DATA, 32'hAB);
    chk("sw_we", {31'b0, REG_WRITE_EN}, 32'h0);

    step(32'h0080_A203, 32'h0, 32'h1000, 32'h0);
    chk("lw_alu", ALU_OUT, 32'h1008);
    chk("lw_mr", {28'b0, MEM_READ}, 32'hA);
    chk("lw_sel", {30'b0, REG_WRITE_SEL}, 32'h0);

    step(32'h1234_53B7, 32'h0, 32'h5555_5555, 32'h7777_7777);
    chk("lui_alu", ALU_OUT, 32'h1234_5000);

    step(32'h4041_5093, 32'h0, 32'h8000_0000, 32'h0);
    chk("srai_alu", ALU_OUT, 32'hF800_0000);

    step(32'h0032_80E7, 32'h300, 32'h1000, 32'h0);
    chk("jalr_alu", ALU_OUT, 32'h1002);
    chk("jalr_tk", {31'b0, BRANCH_TAKEN}, 32'h1);
    chk("jalr_sel", {30'b0, REG_WRITE_SEL}, 32'h3);

    step(32'h0000_007F, 32'h0, 32'h3, 32'h4);
    chk("bad_ctl", {REG_WRITE_EN, MEM_READ[3], MEM_WRITE[2],
                    BRANCH_TAKEN}, 32'h0);

`ifdef M_EXT_EN
    step(32'h0220_C1B3, 32'h0, 32'h7, 32'h0);
    chk("div0", ALU_OUT, 32'hFFFF_FFFF);
    step(32'h0220_E1B3, 32'h0, 32'h7, 32'h0);
    chk("rem0", ALU_OUT, 32'h7);
    step(32'h0220_C1B3, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf", ALU_OUT, 32'h8000_0000);
`else
    step(32'h0220_C1B3, 32'h0, 32'h7, 32'h0);
    chk("div_nop", {31'b0, REG_WRITE_EN}, 32'h0);
`endif

    step(32'h0100_00EF, 32'h200, 32'h0, 32'h0);
    chk("jal_alu", ALU_OUT, 32'h210);
    chk("jal_tk", {31'b0, BRANCH_TAKEN}, 32'h1);
    chk("jal_rd", {27'b0, RD_ADDR}, 32'h1);
    jal_alu = 32'h210;
    jal_pc  = 32'h200;

    STALL = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(32'hFFF0_0293, 32'h40 + k, 32'h11 * k, 32'h22);
      chk("stl_alu", ALU_OUT, jal_alu);
      chk("stl_tk", {31'b0, BRANCH_TAKEN}, 32'h1);
      chk("stl_pc", PC_OUT, jal_pc);
    end

    FLUSH = 1'b1;
    step(32'h0100_00EF, 32'h500, 32'h9, 32'h9);
    chk("fl_alu", ALU_OUT, 32'h0);
    chk("fl_tk", {31'b0, BRANCH_TAKEN}, 32'h0);
    chk("fl_ctl", {REG_WRITE_EN, REG_WRITE_SEL, MEM_READ, MEM_WRITE,
                   RD_ADDR}, 32'h0);
    FLUSH = 1'b0;
    STALL = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32im_decode_exec.md
# rv32im_decode_exec

Registered decode-plus-execute slice of the RV32IM pipeline. Decodes a 32-bit instruction into pipeline control fields and latches them with the operands and immediate into one ID/EX register. From the registered state it computes the ALU result and the branch/jump decision combinationally. It sits between the register-file read and the memory stage; operands arrive already forwarded.

## Interface
Parameters: none.
- CLK  in  1  single clock; all state updates on rising edge
- RESET  in  1  synchronous, active-low reset
- STALL  in  1  hold the ID/EX register (busy-wait from either cache)
- FLUSH  in  1  load a NOP bubble instead of the decoded instruction
- INSTRUCTION  in  32  instruction to decode
- PC_IN  in  32  address of INSTRUCTION
- DATA1, DATA2  in  32  rs1/rs2 values, already forwarded
- ALU_OUT  out  32  ALU result; also the branch/jump target
- BRANCH_TAKEN  out  1  redirect PC to ALU_OUT
- REG_WRITE_EN  out  1  registered write-back enable
- REG_WRITE_SEL  out  2  0 = memory data, 1 = ALU, 2 = zero, 3 = PC+4
- MEM_READ  out  4  bit3 = load enable, [2:0] = funct3
- MEM_WRITE  out  3  bit2 = store enable, [1:0] = funct3[1:0]
- RD_ADDR  out  5  instr[11:7], registered
- STORE_DATA  out  32  registered DATA2
- PC_OUT  out  32  registered PC_IN

## Operation
- Decode by opcode. Unknown opcodes decode to NOP: all enables 0, ALU ADD, no branch.
  - LUI 0110111: ALU FWD with op2 = IMM.
  - AUIPC 0010111: ALU ADD with op1 = PC, op2 = IMM.
  - JAL 1101111, JALR 1100111: REG_WRITE_SEL = 3, branch code 1010.
  - BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
- Operand select: op1 = DATA1 or PC. op2 = DATA2 or IMM.
- Immediates are generated internally and sign-extended:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B and J: LSB forced to 0
  - U: {instr[31:12], 12'b0}
- ALU_SELECT codes (5 bits):
  - 00000 ADD, 00001 SLL, 00010 SLT, 00011 SLTU, 00100 XOR, 00101 SRL, 00110 OR, 00111 AND
  - 10000 SUB, 10101 SRA, 10001 FWD (pass op2)
  - 01000 MUL, 01001 MULH, 01010 MULHSU, 01011 MULHU, 01100 DIV, 01101 DIVU, 01110 REM, 01111 REMU
- Shifts use op2[4:0]. For OP-IMM SRAI, instr[30] selects SRA.
- Division follows RISC-V rules:
  - x/0 gives quotient 0xFFFFFFFF and remainder = x.
  - 0x80000000 / -1 gives quotient 0x80000000 and remainder 0.
- JALR target: ALU_OUT has bit0 cleared.
- Branch codes (4 bits): 1000 BEQ, 1001 BNE, 1100 BLT, 1101 BGE, 1110 BLTU, 1111 BGEU, 1010 unconditional, 0xxx none.
- BRANCH_TAKEN compares the registered DATA1 and DATA2, never the ALU operands.

## Timing
- The ID/EX register updates on CLK rise. Priority: RESET low > FLUSH > STALL > load decoded values.
- On reset, every registered field is 0. Outputs then show ALU_OUT = 0, BRANCH_TAKEN = 0, all enables 0, REG_WRITE_SEL = 0, RD_ADDR = 0.
- FLUSH loads the same all-zero NOP.
- STALL holds all fields. ALU_OUT and BRANCH_TAKEN stay stable while stalled.
- Latency: an instruction presented before edge N has its results valid after edge N, combinationally from the register. No multi-cycle ops; MUL and DIV are single-cycle combinational.

## Configuration
- M_EXT_EN defined: OP with funct7 = 0000001 decodes to the MUL/DIV codes.
- M_EXT_EN undefined: those instructions decode as NOP, and ALU codes 01xxx return 0.

## Test plan
- RESET low for 1 edge with any inputs -> all outputs 0, BRANCH_TAKEN 0.
- ADDI x5, x0, -1 (0xFFF00293), DATA1 = 0 -> ALU_OUT 0xFFFFFFFF, REG_WRITE_EN 1, REG_WRITE_SEL 1, RD_ADDR 5.
- BLT with DATA1 = 0xFFFFFFFF, DATA2 = 1, PC_IN = 0x100, offset +8 -> BRANCH_TAKEN 1, ALU_OUT 0x108. Same operands with BLTU -> BRANCH_TAKEN 0.
- DIV with DATA1 = 7, DATA2 = 0 -> 0xFFFFFFFF. REM with the same operands -> 7. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- SW x2, 4(x1) with DATA1 = 0x1000, DATA2 = 0xAB -> ALU_OUT 0x1004, MEM_WRITE 3'b110, STORE_DATA 0xAB, REG_WRITE_EN 0.
- STALL held 3 cycles after a JAL -> outputs unchanged. Then FLUSH -> NOP state with BRANCH_TAKEN 0.
